// File: rtl/alu_mp_sequencer.sv
// alu_mp_sequencer: chains NBYTES-wide add/sub through an external 8-bit alua, one byte per cycle LSB first.
// Carry/borrow is threaded between bytes; C/V come from the top byte, Z from the assembled result.
module alu_mp_sequencer #(
   parameter int NBYTES = 2,
   localparam int W = 8*NBYTES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         sub,
   input  logic         use_cin,
   input  logic         cin_in,
   input  logic [W-1:0] opa,
   input  logic [W-1:0] opb,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         c_flag,
   output logic         v_flag,
   output logic         z_flag,
   output logic [7:0]   alu_a,
   output logic [7:0]   alu_b,
   output logic [1:0]   alu_sel,
   output logic         alu_cin,
   input  logic [7:0]   alu_out,
   input  logic         alu_cout,
   input  logic         alu_vout
);
   localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
   localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;
   logic [1:0]    r_state;
   logic [IW-1:0] r_idx;
   logic [W-1:0]  r_opa, r_opb, w_res_next;
   logic          r_sub, r_use_cin, r_cin, r_carry;
   logic          w_run, w_first, w_last;
   assign w_run   = r_state == S_RUN;
   assign w_first = r_idx == '0;
   assign w_last  = r_idx == IW'(NBYTES-1);
   assign busy    = w_run;
   assign done    = r_state == S_DONE;
   assign alu_a   = w_run ? r_opa[8*int'(r_idx) +: 8] : 8'h00;
   assign alu_b   = w_run ? r_opb[8*int'(r_idx) +: 8] : 8'h00;
   // byte 0 honours use_cin; higher bytes always chain the previous byte's carry/borrow
   assign alu_sel = w_run ? {r_sub, w_first ? r_use_cin : 1'b1} : 2'b00;
   assign alu_cin = w_run & (w_first ? r_cin : r_carry);
   always_comb begin
      w_res_next = result;
      w_res_next[8*int'(r_idx) +: 8] = alu_out;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_idx     <= '0;
         r_opa     <= '0;
         r_opb     <= '0;
         r_sub     <= 1'b0;
         r_use_cin <= 1'b0;
         r_cin     <= 1'b0;
         r_carry   <= 1'b0;
         result    <= '0;
         c_flag    <= 1'b0;
         v_flag    <= 1'b0;
         z_flag    <= 1'b0;
      end else if (r_state == S_IDLE && start) begin
         r_state   <= S_RUN;
         r_idx     <= '0;
         r_opa     <= opa;
         r_opb     <= opb;
         r_sub     <= sub;
         r_use_cin <= use_cin;
         r_cin     <= cin_in;
         result    <= '0;
         c_flag    <= 1'b0;
         v_flag    <= 1'b0;
         z_flag    <= 1'b0;
      end else if (w_run) begin
         result  <= w_res_next;
         r_carry <= alu_cout;
         r_idx   <= w_last ? r_idx : r_idx + 1'b1;
         if (w_last) begin
            r_state <= S_DONE;
            c_flag  <= alu_cout;
            v_flag  <= alu_vout;
            z_flag  <= w_res_next == '0;
         end
      end else if (done) begin
         r_state <= S_IDLE;
      end
   end
endmodule

// File: tb/tb_alu_mp_sequencer.sv
// tb_alu_mp_sequencer: directed table, hand-written corner sequences and random ops checked against a wide-arithmetic model.
module tb_alu_mp_sequencer;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, sub = 1'b0, use_cin = 1'b0, cin_in = 1'b0;
   logic [15:0] opa = '0, opb = '0, result;
   logic        busy, done, c_flag, v_flag, z_flag, alu_cin, alu_cout, alu_vout;
   logic [7:0]  alu_a, alu_b, alu_out;
   logic [1:0]  alu_sel;
   logic [8:0]  t9;
   int          n_vec = 0, n_err = 0;
   int          dk, nb, nd;
   logic [1:0]  s0, s1;
   logic [18:0] got;

   alu_mp_sequencer #(.NBYTES(2)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .use_cin(use_cin), .cin_in(cin_in),
      .opa(opa), .opb(opb), .busy(busy), .done(done), .result(result),
      .c_flag(c_flag), .v_flag(v_flag), .z_flag(z_flag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
      .alu_out(alu_out), .alu_cout(alu_cout), .alu_vout(alu_vout)
   );

   always #5 clk = ~clk;

   // 8-bit alua stand-in: SEL 00 add, 01 addc, 10 sub, 11 subc; cout is carry or borrow
   always_comb begin
      t9 = alu_sel[1] ? {1'b0, alu_a} - {1'b0, alu_b} - {8'b0, alu_sel[0] & alu_cin}
                      : {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_sel[0] & alu_cin};
      alu_out  = t9[7:0];
      alu_cout = t9[8];
      alu_vout = alu_sel[1] ? (alu_a[7] != alu_b[7]) && (t9[7] != alu_a[7])
                            : (alu_a[7] == alu_b[7]) && (t9[7] != alu_a[7]);
   end

   typedef struct {
      logic s, uc, ci;
      logic [15:0] a, b, r;
      logic c, v, z;
   } vec_t;
   vec_t tv[9];

   function automatic logic [18:0] model(input logic s, uc, ci, input logic [15:0] a, b);
      logic [16:0] f;
      logic        v;
      f = s ? {1'b0, a} - {1'b0, b} - 17'(uc & ci) : {1'b0, a} + {1'b0, b} + 17'(uc & ci);
      v = s ? (a[15] != b[15]) && (f[15] != a[15]) : (a[15] == b[15]) && (f[15] != a[15]);
      return {f[15:0], f[16], v, f[15:0] == 16'h0};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic run_op(input logic s, uc, ci, input logic [15:0] a, b);
      @(negedge clk);
      start = 1'b1; sub = s; use_cin = uc; cin_in = ci; opa = a; opb = b;
      dk = 0; nb = 0; nd = 0; s0 = 2'b00; s1 = 2'b00; got = '0;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (busy) begin
            if (nb == 0) s0 = alu_sel; else s1 = alu_sel;
            nb++;
         end
         if (done) begin
            nd++;
            if (dk == 0) begin dk = k; got = {result, c_flag, v_flag, z_flag}; end
         end
      end
   endtask

   task automatic run_check(input string nm, input logic s, uc, ci, input logic [15:0] a, b, input logic [18:0] exp);
      run_op(s, uc, ci, a, b);
      chk({nm, " latency"}, dk, 3);
      chk({nm, " busy_cycles"}, nb, 2);
      chk({nm, " done_pulses"}, nd, 1);
      chk({nm, " result"}, 32'(got[18:3]), 32'(exp[18:3]));
      chk({nm, " cvz"}, 32'(got[2:0]), 32'(exp[2:0]));
      chk({nm, " sel_byte0"}, 32'(s0), {30'b0, s, uc});
      chk({nm, " sel_byte1"}, 32'(s1), {30'b0, s, 1'b1});
      chk({nm, " held"}, {16'b0, result}, 32'(exp[18:3]));
   endtask

   initial begin
      tv[0] = '{1'b0, 1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0};
      tv[1] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0};
      tv[2] = '{1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
      tv[3] = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
      tv[4] = '{1'b0, 1'b1, 1'b1, 16'h1234, 16'h0001, 16'h1236, 1'b0, 1'b0, 1'b0};
      tv[5] = '{1'b1, 1'b0, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0};
      tv[6] = '{1'b1, 1'b1, 1'b1, 16'h0005, 16'h0005, 16'hFFFF, 1'b1, 1'b0, 1'b0};
      tv[7] = '{1'b1, 1'b0, 1'b0, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1};
      tv[8] = '{1'b0, 1'b0, 1'b1, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0};
      #2;
      chk("reset_ctrl", {26'b0, busy, done, c_flag, v_flag, z_flag, alu_cin}, 32'h0);
      chk("reset_result", {16'b0, result}, 32'h0);
      chk("reset_alu", {14'b0, alu_a, alu_b, alu_sel}, 32'h0);
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 9; i++)
         run_check($sformatf("table%0d", i), tv[i].s, tv[i].uc, tv[i].ci, tv[i].a, tv[i].b,
                   {tv[i].r, tv[i].c, tv[i].v, tv[i].z});

      // start re-pulsed during RUN with other operands must be ignored
      @(negedge clk);
      start = 1'b1; sub = 1'b0; use_cin = 1'b0; cin_in = 1'b0; opa = 16'h1111; opb = 16'h2222;
      nd = 0; got = '0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin sub = 1'b1; opa = 16'h9999; opb = 16'h0999; end
         if (k == 3) start = 1'b0;
         if (done) begin nd++; got = {result, c_flag, v_flag, z_flag}; end
      end
      chk("midrun_done_pulses", nd, 1);
      chk("midrun_result", 32'(got[18:3]), 32'h3333);
      chk("midrun_idle_after", {31'b0, busy}, 32'h0);

      // async reset during byte 1 discards the op
      @(negedge clk);
      start = 1'b1; sub = 1'b0; use_cin = 1'b0; opa = 16'hA5C3; opb = 16'h0102;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      chk("rst_pre_busy", {31'b0, busy}, 32'h1);
      rst = 1'b1; #1;
      chk("rst_mid_ctrl", {26'b0, busy, done, c_flag, v_flag, z_flag, alu_cin}, 32'h0);
      chk("rst_mid_result", {16'b0, result}, 32'h0);
      chk("rst_mid_alu", {14'b0, alu_a, alu_b, alu_sel}, 32'h0);
      @(negedge clk); rst = 1'b0;
      nd = 0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         if (done || busy) nd++;
      end
      chk("rst_no_activity", nd, 0);
      run_check("after_rst", 1'b0, 1'b0, 1'b0, 16'h00FF, 16'h0001, {16'h0100, 3'b000});

      for (int i = 0; i < 40; i++) begin
         logic s, uc, ci;
         logic [15:0] a, b;
         s = 1'($urandom); uc = 1'($urandom); ci = 1'($urandom);
         a = 16'($urandom); b = 16'($urandom);
         if (i % 8 == 0) b = a;
         run_check($sformatf("rand%0d", i), s, uc, ci, a, b, model(s, uc, ci, a, b));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
